// File: rtl/frat_ckpt.sv
// Front-end register alias table: renames up to ISSUE_W instructions per
// cycle to ROB tags, clears entries on retire, and keeps a ring of branch
// checkpoints for single-cycle mispredict recovery.
module frat_ckpt #(
    parameter int ISSUE_W   = 2,
    parameter int RET_W     = 2,
    parameter int ARCH_REGS = 32,
    parameter int ROB_DEPTH = 64,
    parameter int NUM_CKPT  = 4,
    localparam int TAG_W    = $clog2(ROB_DEPTH),
    localparam int CK_W     = $clog2(NUM_CKPT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ISSUE_W-1:0]           is_val,
    input  logic [ISSUE_W-1:0]           is_wr,
    input  logic [ISSUE_W-1:0]           is_br,
    input  logic [ISSUE_W*5-1:0]         is_rd,
    input  logic [ISSUE_W*5-1:0]         is_rs1,
    input  logic [ISSUE_W*5-1:0]         is_rs2,
    input  logic [TAG_W-1:0]             rob_tail,
    output logic                         is_ready,
    output logic [ISSUE_W-1:0]           ren_val,
    output logic [ISSUE_W*2*TAG_W-1:0]   ren_tag,
    output logic [ISSUE_W*2-1:0]         ren_busy,
    output logic [ISSUE_W*TAG_W-1:0]     ren_robid,
    output logic [CK_W-1:0]              ren_ckpt,
    input  logic [RET_W-1:0]             ret_val,
    input  logic [RET_W-1:0]             ret_wr,
    input  logic [RET_W*5-1:0]           ret_rd,
    input  logic [RET_W*TAG_W-1:0]       ret_robid,
    input  logic                         ck_release,
    input  logic                         flush,
    input  logic [CK_W-1:0]              flush_ckpt,
    output logic                         ckpt_full
);

    localparam int RW    = 5;
    localparam int CNT_W = CK_W + 1;

    // Architectural table and checkpoint ring
    logic             busy_q [ARCH_REGS];
    logic [TAG_W-1:0] tag_q  [ARCH_REGS];
    logic             busy_d [ARCH_REGS];
    logic [TAG_W-1:0] tag_d  [ARCH_REGS];

    logic             ck_busy_q [NUM_CKPT][ARCH_REGS];
    logic [TAG_W-1:0] ck_tag_q  [NUM_CKPT][ARCH_REGS];
    logic             ck_busy_d [NUM_CKPT][ARCH_REGS];
    logic [TAG_W-1:0] ck_tag_d  [NUM_CKPT][ARCH_REGS];

    logic [CK_W-1:0]  head_q, head_d;
    logic [CK_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Registered rename outputs
    logic [ISSUE_W-1:0]         ren_val_q;
    logic [ISSUE_W*2*TAG_W-1:0] ren_tag_q, ren_tag_d;
    logic [ISSUE_W*2-1:0]       ren_busy_q, ren_busy_d;
    logic [ISSUE_W*TAG_W-1:0]   ren_robid_q, ren_robid_d;
    logic [CK_W-1:0]            ren_ckpt_q;

    // Unpacked views of the flattened inputs
    logic [RW-1:0]    rd_a   [ISSUE_W];
    logic [RW-1:0]    rs_a   [ISSUE_W][2];
    logic [RW-1:0]    rret_rd  [RET_W];
    logic [TAG_W-1:0] rret_tag [RET_W];
    logic [RET_W-1:0] ret_hit;

    logic [ISSUE_W-1:0] slot_v;
    logic [TAG_W-1:0]   robid [ISSUE_W];
    logic               br_any;
    logic [31:0]        br_idx;
    logic               rel;

    // Snapshot of the table after the branch slot's writes
    logic             snap_b [ARCH_REGS];
    logic [TAG_W-1:0] snap_t [ARCH_REGS];
    // Checkpoints with this cycle's retire clears applied
    logic             ckc_b  [NUM_CKPT][ARCH_REGS];

    assign ckpt_full = (count_q == CNT_W'(NUM_CKPT));
    assign is_ready  = ~ckpt_full & ~flush;

    assign ren_val   = ren_val_q;
    assign ren_tag   = ren_tag_q;
    assign ren_busy  = ren_busy_q;
    assign ren_robid = ren_robid_q;
    assign ren_ckpt  = ren_ckpt_q;

    // Split flattened ports into per-slot / per-port fields
    always_comb begin
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            rd_a[i]    = is_rd[i*RW +: RW];
            rs_a[i][0] = is_rs1[i*RW +: RW];
            rs_a[i][1] = is_rs2[i*RW +: RW];
        end
        for (int unsigned k = 0; k < RET_W; k++) begin
            rret_rd[k]  = ret_rd[k*RW +: RW];
            rret_tag[k] = ret_robid[k*TAG_W +: TAG_W];
            ret_hit[k]  = ret_val[k] & ret_wr[k];
        end
    end

    // Slot gating, destination ROB ids and the allocating branch slot
    always_comb begin
        logic [TAG_W-1:0] cnt;
        cnt    = rob_tail;
        br_any = 1'b0;
        br_idx = '0;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            slot_v[i] = is_val[i] & is_ready;
            robid[i]  = cnt;
            if (slot_v[i]) begin
                cnt = cnt + TAG_W'(1);
            end
            if (slot_v[i] && is_br[i] && !br_any) begin
                br_any = 1'b1;
                br_idx = i;
            end
        end
    end

    // Source lookup: intra-group bypass over table read with retire bypass
    always_comb begin
        logic [RW-1:0]    rs;
        logic             b;
        logic [TAG_W-1:0] t;
        ren_busy_d  = '0;
        ren_tag_d   = '0;
        ren_robid_d = '0;
        rs = '0;
        b  = 1'b0;
        t  = '0;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            ren_robid_d[i*TAG_W +: TAG_W] = robid[i];
            for (int unsigned s = 0; s < 2; s++) begin
                rs = rs_a[i][s];
                b  = busy_q[rs];
                t  = tag_q[rs];
                for (int unsigned k = 0; k < RET_W; k++) begin
                    if (ret_hit[k] && rret_tag[k] == t) begin
                        b = 1'b0;
                    end
                end
                // Later slots overwrite earlier ones, so the youngest producer wins
                for (int unsigned j = 0; j < i; j++) begin
                    if (slot_v[j] && is_wr[j] && rd_a[j] == rs) begin
                        b = 1'b1;
                        t = robid[j];
                    end
                end
                if (rs == '0) begin
                    b = 1'b0;
                    t = '0;
                end
                ren_busy_d[i*2+s]            = b;
                ren_tag_d[(i*2+s)*TAG_W +: TAG_W] = t;
            end
        end
    end

    // Next table state, branch snapshot and checkpoint updates
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int unsigned k = 0; k < RET_W; k++) begin
            if (ret_hit[k] && tag_q[rret_rd[k]] == rret_tag[k]) begin
                busy_d[rret_rd[k]] = 1'b0;
            end
        end
        snap_b = busy_d;
        snap_t = tag_d;
        // Writes are applied in slot order so the highest slot wins and
        // issue overrides the retire clear applied above
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            if (slot_v[i] && is_wr[i] && rd_a[i] != '0) begin
                busy_d[rd_a[i]] = 1'b1;
                tag_d[rd_a[i]]  = robid[i];
            end
            if (br_any && br_idx == i) begin
                snap_b = busy_d;
                snap_t = tag_d;
            end
        end

        ckc_b = ck_busy_q;
        for (int unsigned c = 0; c < NUM_CKPT; c++) begin
            for (int unsigned k = 0; k < RET_W; k++) begin
                if (ret_hit[k] && ck_tag_q[c][rret_rd[k]] == rret_tag[k]) begin
                    ckc_b[c][rret_rd[k]] = 1'b0;
                end
            end
        end

        ck_busy_d = ckc_b;
        ck_tag_d  = ck_tag_q;
        if (br_any) begin
            ck_busy_d[tail_q] = snap_b;
            ck_tag_d[tail_q]  = snap_t;
        end

        if (flush) begin
            busy_d = ckc_b[flush_ckpt];
            tag_d  = ck_tag_q[flush_ckpt];
        end
    end

    // Checkpoint ring pointers and occupancy
    always_comb begin
        rel    = ck_release & (count_q != '0);
        head_d = head_q + CK_W'(rel);
        if (flush) begin
            // Occupancy spans head through the restored checkpoint inclusive
            tail_d  = flush_ckpt + CK_W'(1);
            count_d = CNT_W'(flush_ckpt - head_q) + CNT_W'(1) - CNT_W'(rel);
        end else begin
            tail_d  = tail_q + CK_W'(br_any);
            count_d = count_q + CNT_W'(br_any) - CNT_W'(rel);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < ARCH_REGS; r++) begin
                busy_q[r] <= 1'b0;
                tag_q[r]  <= '0;
            end
            for (int unsigned c = 0; c < NUM_CKPT; c++) begin
                for (int unsigned r = 0; r < ARCH_REGS; r++) begin
                    ck_busy_q[c][r] <= 1'b0;
                    ck_tag_q[c][r]  <= '0;
                end
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ren_val_q   <= '0;
            ren_tag_q   <= '0;
            ren_busy_q  <= '0;
            ren_robid_q <= '0;
            ren_ckpt_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            tag_q       <= tag_d;
            ck_busy_q   <= ck_busy_d;
            ck_tag_q    <= ck_tag_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ren_val_q   <= slot_v;
            ren_tag_q   <= ren_tag_d;
            ren_busy_q  <= ren_busy_d;
            ren_robid_q <= ren_robid_d;
            ren_ckpt_q  <= tail_q;
        end
    end

endmodule

// File: tb/tb_frat_ckpt.sv
// Directed bench for frat_ckpt: rename, bypass, retire, checkpoint ring and flush.
module tb_frat_ckpt;

    localparam int ISSUE_W = 2;
    localparam int RET_W   = 2;
    localparam int TAG_W   = 6;
    localparam int CK_W    = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [ISSUE_W-1:0]         is_val, is_wr, is_br;
    logic [ISSUE_W*5-1:0]       is_rd, is_rs1, is_rs2;
    logic [TAG_W-1:0]           rob_tail;
    logic                       is_ready;
    logic [ISSUE_W-1:0]         ren_val;
    logic [ISSUE_W*2*TAG_W-1:0] ren_tag;
    logic [ISSUE_W*2-1:0]       ren_busy;
    logic [ISSUE_W*TAG_W-1:0]   ren_robid;
    logic [CK_W-1:0]            ren_ckpt;
    logic [RET_W-1:0]           ret_val, ret_wr;
    logic [RET_W*5-1:0]         ret_rd;
    logic [RET_W*TAG_W-1:0]     ret_robid;
    logic                       ck_release, flush;
    logic [CK_W-1:0]            flush_ckpt;
    logic                       ckpt_full;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    frat_ckpt #(
        .ISSUE_W(ISSUE_W), .RET_W(RET_W), .ARCH_REGS(32), .ROB_DEPTH(64), .NUM_CKPT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .is_val(is_val), .is_wr(is_wr), .is_br(is_br),
        .is_rd(is_rd), .is_rs1(is_rs1), .is_rs2(is_rs2),
        .rob_tail(rob_tail), .is_ready(is_ready),
        .ren_val(ren_val), .ren_tag(ren_tag), .ren_busy(ren_busy),
        .ren_robid(ren_robid), .ren_ckpt(ren_ckpt),
        .ret_val(ret_val), .ret_wr(ret_wr), .ret_rd(ret_rd), .ret_robid(ret_robid),
        .ck_release(ck_release), .flush(flush), .flush_ckpt(flush_ckpt),
        .ckpt_full(ckpt_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        is_val = '0; is_wr = '0; is_br = '0;
        is_rd = '0; is_rs1 = '0; is_rs2 = '0;
        rob_tail = '0;
        ret_val = '0; ret_wr = '0; ret_rd = '0; ret_robid = '0;
        ck_release = 1'b0; flush = 1'b0; flush_ckpt = '0;
    endtask

    task automatic slot(input int i, input logic w, input logic b,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        is_val[i] = 1'b1;
        is_wr[i]  = w;
        is_br[i]  = b;
        is_rd[i*5 +: 5]  = rd;
        is_rs1[i*5 +: 5] = r1;
        is_rs2[i*5 +: 5] = r2;
    endtask

    task automatic retire(input int k, input logic [4:0] rd, input logic [TAG_W-1:0] id);
        ret_val[k] = 1'b1;
        ret_wr[k]  = 1'b1;
        ret_rd[k*5 +: 5] = rd;
        ret_robid[k*TAG_W +: TAG_W] = id;
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic bsy(input int i, input int s);
        return ren_busy[i*2+s];
    endfunction

    function automatic logic [TAG_W-1:0] tg(input int i, input int s);
        return ren_tag[(i*2+s)*TAG_W +: TAG_W];
    endfunction

    function automatic logic [TAG_W-1:0] rid(input int i);
        return ren_robid[i*TAG_W +: TAG_W];
    endfunction

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        do_reset();
        check("rst_ren_val", 32'(ren_val), 0);
        check("rst_full", 32'(ckpt_full), 0);
        check("rst_ready", 32'(is_ready), 1);
        check("rst_busy", 32'(ren_busy), 0);

        // Fresh table: x5/x6 read the register file
        clr_in();
        slot(0, 0, 0, 0, 5, 6);
        slot(1, 0, 0, 0, 6, 5);
        step();
        check("fresh_val", 32'(ren_val), 3);
        check("fresh_busy", 32'(ren_busy), 0);
        check("fresh_tag", 32'(ren_tag), 0);
        check("fresh_robid1", 32'(rid(1)), 1);

        // Intra-group bypass with robid wrap 62 -> 63
        clr_in();
        rob_tail = 6'd62;
        slot(0, 1, 0, 3, 0, 0);
        slot(1, 1, 0, 3, 3, 0);
        step();
        check("byp_robid0", 32'(rid(0)), 62);
        check("byp_robid1", 32'(rid(1)), 63);
        check("byp_busy", 32'(bsy(1, 0)), 1);
        check("byp_tag", 32'(tg(1, 0)), 62);
        check("x0_busy", 32'(bsy(1, 1)), 0);

        // Highest writer in the group owns x3
        clr_in();
        slot(0, 0, 0, 0, 3, 0);
        step();
        check("x3_val", 32'(ren_val), 1);
        check("x3_busy", 32'(bsy(0, 0)), 1);
        check("x3_tag", 32'(tg(0, 0)), 63);

        // Retire bypass on a matching tag
        clr_in();
        rob_tail = 6'd10;
        slot(0, 1, 0, 4, 0, 0);
        step();
        clr_in();
        slot(0, 0, 0, 0, 4, 0);
        retire(0, 4, 6'd10);
        step();
        check("ret_byp_busy", 32'(bsy(0, 0)), 0);
        clr_in();
        slot(0, 0, 0, 0, 4, 0);
        step();
        check("ret_clr_busy", 32'(bsy(0, 0)), 0);

        // Retire of a stale tag leaves x4 busy
        clr_in();
        rob_tail = 6'd11;
        slot(0, 1, 0, 4, 0, 0);
        step();
        clr_in();
        slot(0, 0, 0, 0, 4, 0);
        retire(1, 4, 6'd9);
        step();
        check("stale_busy", 32'(bsy(0, 0)), 1);
        check("stale_tag", 32'(tg(0, 0)), 11);
        clr_in();
        slot(0, 0, 0, 0, 0, 4);
        step();
        check("stale_keep", 32'(bsy(0, 1)), 1);

        // Fill the ring: checkpoints 0..3
        for (int n = 0; n < 4; n++) begin
            clr_in();
            slot(0, 0, 1, 0, 0, 0);
            step();
            check("alloc_id", 32'(ren_ckpt), 32'(n));
        end
        check("full_set", 32'(ckpt_full), 1);
        check("full_ready", 32'(is_ready), 0);
        clr_in();
        ck_release = 1'b1;
        #1;
        check("rel_ready_same", 32'(is_ready), 0);
        step();
        check("rel_full", 32'(ckpt_full), 0);
        check("rel_ready", 32'(is_ready), 1);
        clr_in();
        slot(0, 0, 1, 0, 0, 0);
        step();
        check("wrap_id", 32'(ren_ckpt), 0);
        check("wrap_full", 32'(ckpt_full), 1);

        // Reset mid-operation
        clr_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_val", 32'(ren_val), 0);
        check("mid_tag", 32'(ren_tag), 0);
        check("mid_robid", 32'(ren_robid), 0);
        check("mid_ckpt", 32'(ren_ckpt), 0);
        check("mid_full", 32'(ckpt_full), 0);
        clr_in();
        slot(0, 0, 0, 0, 3, 4);
        step();
        check("mid_clean", 32'(ren_busy), 0);

        // Checkpoint 1 snapshots x7=20, later overwritten by 25, then restore
        clr_in();
        slot(0, 0, 1, 0, 0, 0);
        step();
        clr_in();
        rob_tail = 6'd20;
        slot(0, 1, 0, 7, 0, 0);
        slot(1, 0, 1, 0, 0, 0);
        step();
        check("snap_id", 32'(ren_ckpt), 1);
        clr_in();
        rob_tail = 6'd25;
        slot(0, 1, 0, 7, 0, 0);
        step();
        clr_in();
        slot(0, 0, 0, 0, 7, 0);
        step();
        check("x7_new", 32'(tg(0, 0)), 25);
        clr_in();
        flush = 1'b1;
        flush_ckpt = 2'd1;
        rob_tail = 6'd40;
        slot(0, 1, 0, 7, 0, 0);
        #1;
        check("flush_ready", 32'(is_ready), 0);
        step();
        check("flush_val", 32'(ren_val), 0);
        clr_in();
        slot(0, 0, 0, 0, 7, 0);
        slot(1, 0, 1, 0, 0, 0);
        step();
        check("x7_rest_busy", 32'(bsy(0, 0)), 1);
        check("x7_rest_tag", 32'(tg(0, 0)), 20);
        check("flush_tail", 32'(ren_ckpt), 2);
        check("flush_cnt3", 32'(ckpt_full), 0);
        clr_in();
        slot(0, 0, 1, 0, 0, 0);
        step();
        check("flush_id3", 32'(ren_ckpt), 3);
        check("flush_cnt4", 32'(ckpt_full), 1);

        // Retire clears a checkpointed entry before it is restored
        do_reset();
        clr_in();
        rob_tail = 6'd30;
        slot(0, 1, 0, 8, 0, 0);
        slot(1, 0, 1, 0, 0, 0);
        step();
        check("ck8_id", 32'(ren_ckpt), 0);
        clr_in();
        rob_tail = 6'd31;
        slot(0, 1, 0, 8, 0, 0);
        step();
        clr_in();
        slot(0, 0, 0, 0, 8, 0);
        retire(0, 8, 6'd30);
        step();
        check("x8_live_busy", 32'(bsy(0, 0)), 1);
        check("x8_live_tag", 32'(tg(0, 0)), 31);
        clr_in();
        flush = 1'b1;
        flush_ckpt = 2'd0;
        step();
        clr_in();
        slot(0, 0, 0, 0, 8, 0);
        step();
        check("x8_restored", 32'(bsy(0, 0)), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frat_ckpt.md
# frat_ckpt

Parametrised front-end register alias table with multi-slot rename, intra-group bypass, retire-clear and a ring of branch checkpoints for single-cycle mispredict recovery. It sits between decode and ROB allocation and generalises issue width, retire width, architectural register count and checkpoint depth. It renames up to ISSUE_W instructions per cycle to ROB tags, or to the committed register file when the tag is not busy.

## Interface
- ISSUE_W, 2, rename slots per cycle
- RET_W, 2, retire ports per cycle
- ARCH_REGS, 32, architectural registers; x0 is hard-wired
- ROB_DEPTH, 64, ROB entries (power of 2); TAG_W = clog2(ROB_DEPTH)
- NUM_CKPT, 4, checkpoint entries (power of 2); CK_W = clog2(NUM_CKPT)
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- is_val  in  ISSUE_W  slot valid; upstream asserts only while is_ready=1
- is_wr  in  ISSUE_W  slot writes rd
- is_br  in  ISSUE_W  slot is a branch; at most one per group
- is_rd, is_rs1, is_rs2  in  ISSUE_W×5  architectural indices
- rob_tail  in  TAG_W  ROB tag of slot 0 this cycle
- is_ready  out  1  = ~ckpt_full & ~flush
- ren_val  out  ISSUE_W  registered copy of is_val
- ren_tag  out  ISSUE_W×2×TAG_W  source tags (rs1 at index 0, rs2 at index 1)
- ren_busy  out  ISSUE_W×2  1 = wait on ROB tag, 0 = read PRF
- ren_robid  out  ISSUE_W×TAG_W  destination ROB tag per slot
- ren_ckpt  out  CK_W  checkpoint id allocated for the branch in the group
- ret_val, ret_wr  in  RET_W  retire valid / retiring op writes rd
- ret_rd  in  RET_W×5;  ret_robid  in  RET_W×TAG_W
- ck_release  in  1  oldest branch retired; free the head checkpoint
- flush  in  1  mispredict restore
- flush_ckpt  in  CK_W  checkpoint to restore
- ckpt_full  out  1  all NUM_CKPT entries allocated

## Operation
- Table entry per arch reg: {busy, tag}. Reset: all busy=0 and tag=0. Checkpoint ring head=tail=0, count=0.
- Slot robid: rob_tail + (number of valid slots below i), mod ROB_DEPTH.
- Source lookup: the youngest earlier slot j<i with is_val&is_wr and is_rd==rs wins → {busy=1, tag=robid_j}. Otherwise use the table entry. A busy entry whose tag matches any ret_val&ret_wr robid this cycle reads busy=0. rs==x0 always returns busy=0, tag=0.
- Table write:
  - Issue: for each rd (≠x0), the highest slot with is_val&is_wr writes {1, robid}.
  - Retire: clears busy only where entry.tag==ret_robid and no issue slot writes that rd this cycle. Issue beats retire.
- Checkpoint alloc on a valid is_br slot: slot[tail] ← table state after applying the writes of slots ≤ the branch slot (and the same-cycle retire clears). Then tail++, count++. ren_ckpt ← old tail.
- Retire clears are also applied to every allocated checkpoint with matching {rd, tag}.
- ck_release: head++, count--. Ignored when count=0.
- flush: table ← checkpoint[flush_ckpt] with that cycle's retire clears applied. tail ← flush_ckpt+1 (mod NUM_CKPT). count recomputed from head. Issue inputs are ignored; ren_val ← 0 next cycle. Simultaneous ck_release is applied to head.
- Two is_br in one group is an upstream error; only the lowest slot allocates.

## Timing
- Rename outputs are registered: 1-cycle latency from is_val to ren_*.
- Table and checkpoint updates are visible to lookups on the next cycle. Same-cycle retire is bypassed combinationally.
- is_ready is combinational from state and flush.
- Reset mid-operation: the next cycle has ren_val=0, ren_busy=0, ren_tag=0, ren_robid=0, ren_ckpt=0, ckpt_full=0, and the table is clean.
- Full: count==NUM_CKPT → ckpt_full=1 and is_ready=0. A release in the same cycle does not affect is_ready until the next cycle.
- Wrap-around: robid and ring pointers wrap modulo their depth.

## Test plan
- Reset, then rename x5,x6 → ren_busy=0,0 and ren_tag=0.
- Slot0 writes x3 with rob_tail=62, slot1 reads x3 → slot1 rs1 busy=1, tag=62, slot1 robid=63. Next cycle with rob_tail=0, a read of x3 → tag=63 if slot1 wrote x3, else 62.
- x4 renamed to tag 10; retire robid 10 rd 4 in the same cycle as a read of x4 → busy=0. Retire robid 9 rd 4 → x4 stays busy.
- Four branches allocate checkpoints 0..3 → ckpt_full=1, is_ready=0. ck_release → ckpt_full=0 next cycle, and the next branch gets ckpt 0.
- Branch at ckpt 1 snapshots x7=tag 20. Later x7 is renamed to 25. flush with flush_ckpt=1 → x7 reads tag 20, tail=2, count=2 (head=0).
- Checkpoint holds x8 busy tag 30. Retire robid 30 rd 8, then flush to that checkpoint → x8 reads busy=0.
